fifo_load_arbiter: RTL and testbench

- Shares one write port of the capture FIFO between two source channels (CH1, CH2), then drains the FIFO to the consumer.
- Arbitrates channel requests round-robin and steers the FIFO input mux toward the granted channel.
- Writes one burst of up to BURST_LEN words, then reads the FIFO until empty before accepting the next request.
- Sits between the channel sources and the FIFO; it replaces ad-hoc per-frame channel selection.

---
 rtl/fifo_load_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_load_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_load_arbiter.sv
// Round-robin arbiter sharing one capture FIFO write port between CH1 and CH2.
// Define ARB_FIXED_PRIO_EN for fixed CH1-first priority instead of round-robin.
module fifo_load_arbiter #(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_ch1,
    input  logic             req_ch2,
    input  logic             valid_ch1,
    input  logic             valid_ch2,
    input  logic             fifo_full,
    input  logic             fifo_empty,
    output logic             mux_sel,
    output logic             fifo_wr,
    output logic             fifo_rd,
    output logic             gnt_ch1,
    output logic             gnt_ch2,
    output logic             ack_ch1,
    output logic             ack_ch2,
    output logic             ready,
    output logic [CNT_W-1:0] burst_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FINISH,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_gnt1;
    logic             r_gnt2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             w_req_any;
    logic             w_pick1;
    logic             w_req_sel;
    logic             w_valid_sel;
    logic             w_last;
    logic             w_wr;
    logic             w_take;

    assign w_req_any   = req_ch1 | req_ch2;
    assign w_req_sel   = r_gnt1 ? req_ch1 : req_ch2;
    assign w_valid_sel = r_gnt1 ? valid_ch1 : valid_ch2;
    assign w_last      = (r_cnt == CNT_W'(BURST_LEN - 1));
    assign w_take      = (r_state == S_IDLE) & w_req_any;
    assign burst_cnt   = r_burst_cnt;

`ifdef ARB_FIXED_PRIO_EN
    assign w_pick1 = req_ch1;
`else
    logic r_last1;

    assign w_pick1 = req_ch1 & (~req_ch2 | ~r_last1);

    // Remember the last winner so a tie alternates; reset favours CH1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last1 <= 1'b0;
        end else if (w_take) begin
            r_last1 <= w_pick1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant latch, word counter and completed-burst length.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt1      <= 1'b0;
            r_gnt2      <= 1'b0;
            r_cnt       <= '0;
            r_burst_cnt <= '0;
        end else begin
            if (w_take) begin
                r_gnt1 <= w_pick1;
                r_gnt2 <= ~w_pick1;
            end
            if (w_wr) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_FINISH) begin
                r_burst_cnt <= r_cnt;
                r_cnt       <= '0;
                r_gnt1      <= 1'b0;
                r_gnt2      <= 1'b0;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next  = r_state;
        w_wr    = 1'b0;
        ready   = 1'b0;
        mux_sel = 1'b0;
        gnt_ch1 = 1'b0;
        gnt_ch2 = 1'b0;
        fifo_rd = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (w_req_any) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                gnt_ch1 = r_gnt1;
                gnt_ch2 = r_gnt2;
                mux_sel = r_gnt1;
                if (fifo_full) begin
                    w_next = S_FINISH;
                end else if (!w_req_sel) begin
                    w_next = S_FINISH;
                end else begin
                    w_wr = w_valid_sel;
                    if (w_valid_sel && w_last) begin
                        w_next = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    w_next = S_IDLE;
                end else begin
                    fifo_rd = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign fifo_wr = w_wr;
    assign ack_ch1 = w_wr & r_gnt1;
    assign ack_ch2 = w_wr & r_gnt2;

endmodule

// File: tb/tb_fifo_load_arbiter.sv
// Table-driven bench for fifo_load_arbiter with BURST_LEN=4.
// Expected outputs are queued as each row is driven and popped on sampling.
module tb_fifo_load_arbiter;

    localparam int BL = 4;
    localparam int CW = 4;

    // Output vector order: {ready,gnt1,gnt2,mux,wr,rd,ack1,ack2}
    localparam logic [7:0] IDL = 8'b1000_0000;
    localparam logic [7:0] ZER = 8'b0000_0000;
    localparam logic [7:0] DRN = 8'b0000_0100;
    localparam logic [7:0] L1W = 8'b0101_1010;
    localparam logic [7:0] L1S = 8'b0101_0000;
    localparam logic [7:0] L2W = 8'b0010_1001;
    localparam logic [7:0] L2S = 8'b0010_0000;

    typedef struct packed {
        logic [5:0]  in;   // {req1,req2,v1,v2,full,empty}
        logic [11:0] exp;  // {outputs, burst_cnt}
    } vec_t;

    logic          clk;
    logic          reset;
    logic          req_ch1;
    logic          req_ch2;
    logic          valid_ch1;
    logic          valid_ch2;
    logic          fifo_full;
    logic          fifo_empty;
    logic          mux_sel;
    logic          fifo_wr;
    logic          fifo_rd;
    logic          gnt_ch1;
    logic          gnt_ch2;
    logic          ack_ch1;
    logic          ack_ch2;
    logic          ready;
    logic [CW-1:0] burst_cnt;

    int errors = 0;
    int checks = 0;
    logic [11:0] sb[$];

    fifo_load_arbiter #(
        .BURST_LEN(BL),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_ch1   (req_ch1),
        .req_ch2   (req_ch2),
        .valid_ch1 (valid_ch1),
        .valid_ch2 (valid_ch2),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .mux_sel   (mux_sel),
        .fifo_wr   (fifo_wr),
        .fifo_rd   (fifo_rd),
        .gnt_ch1   (gnt_ch1),
        .gnt_ch2   (gnt_ch2),
        .ack_ch1   (ack_ch1),
        .ack_ch2   (ack_ch2),
        .ready     (ready),
        .burst_cnt (burst_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [5:0] i, input logic [7:0] o,
                                input logic [3:0] bc);
        vec_t v;
        v.in  = i;
        v.exp = {o, bc};
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        logic [11:0] act;
        logic [11:0] exp;
        {req_ch1, req_ch2, valid_ch1, valid_ch2, fifo_full, fifo_empty} = v.in;
        sb.push_back(v.exp);
        #2;
        act = {ready, gnt_ch1, gnt_ch2, mux_sel, fifo_wr, fifo_rd,
               ack_ch1, ack_ch2, burst_cnt};
        exp = sb.pop_front();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got out=%b cnt=%0d want out=%b cnt=%0d",
                     nm, act[11:4], act[3:0], exp[11:4], exp[3:0]);
        end
        @(negedge clk);
    endtask

    task automatic run(input vec_t t[$], input string nm);
        foreach (t[k]) apply(t[k], $sformatf("%s[%0d]", nm, k));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        apply(mk(6'b110001, IDL, 4'd0), "in_reset");
        reset = 1'b1;
    endtask

    initial begin
        vec_t t[$];
        logic g1;
        reset      = 1'b0;
        req_ch1    = 1'b0;
        req_ch2    = 1'b0;
        valid_ch1  = 1'b0;
        valid_ch2  = 1'b0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b1;
        @(negedge clk);
        do_reset();

        // Full CH1 burst, then drain two words.
        t = {};
        t.push_back(mk(6'b101001, IDL, 4'd0));
        t.push_back(mk(6'b101001, L1W, 4'd0));
        t.push_back(mk(6'b101001, L1W, 4'd0));
        t.push_back(mk(6'b101001, L1W, 4'd0));
        t.push_back(mk(6'b101001, L1W, 4'd0));
        t.push_back(mk(6'b000000, ZER, 4'd0));
        t.push_back(mk(6'b000000, DRN, 4'd4));
        t.push_back(mk(6'b000000, DRN, 4'd4));
        t.push_back(mk(6'b000001, ZER, 4'd4));
        t.push_back(mk(6'b000001, IDL, 4'd4));
        run(t, "burst1");

        // Both channels requesting for three bursts.
        do_reset();
        for (int b = 0; b < 3; b++) begin
`ifdef ARB_FIXED_PRIO_EN
            g1 = 1'b1;
`else
            g1 = (b % 2 == 0);
`endif
            apply(mk(6'b111101, IDL, (b == 0) ? 4'd0 : 4'd4),
                  $sformatf("tie%0d_idle", b));
            for (int w = 0; w < BL; w++) begin
                apply(mk(6'b111101, g1 ? L1W : L2W,
                         (b == 0) ? 4'd0 : 4'd4),
                      $sformatf("tie%0d_w%0d", b, w));
            end
            apply(mk(6'b111101, ZER, (b == 0) ? 4'd0 : 4'd4),
                  $sformatf("tie%0d_fin", b));
            apply(mk(6'b111101, ZER, 4'd4),
                  $sformatf("tie%0d_drn", b));
        end

        // CH2 burst cut short by fifo_full; drain already empty.
        do_reset();
        t = {};
        t.push_back(mk(6'b010101, IDL, 4'd0));
        t.push_back(mk(6'b010101, L2W, 4'd0));
        t.push_back(mk(6'b010101, L2W, 4'd0));
        t.push_back(mk(6'b010111, L2S, 4'd0));
        t.push_back(mk(6'b000001, ZER, 4'd0));
        t.push_back(mk(6'b000001, ZER, 4'd2));
        t.push_back(mk(6'b000001, IDL, 4'd2));
        run(t, "full");

        // CH1 with valid stalls, then req drops; CH2 valid held high.
        do_reset();
        t = {};
        t.push_back(mk(6'b101100, IDL, 4'd0));
        t.push_back(mk(6'b101100, L1W, 4'd0));
        t.push_back(mk(6'b100100, L1S, 4'd0));
        t.push_back(mk(6'b101100, L1W, 4'd0));
        t.push_back(mk(6'b101100, L1W, 4'd0));
        t.push_back(mk(6'b001100, L1S, 4'd0));
        t.push_back(mk(6'b000100, ZER, 4'd0));
        t.push_back(mk(6'b000100, DRN, 4'd3));
        t.push_back(mk(6'b000101, ZER, 4'd3));
        t.push_back(mk(6'b000101, IDL, 4'd3));
        run(t, "abort");

        // Reset asserted mid-LOAD, then a tie.
        apply(mk(6'b101001, IDL, 4'd3), "rl_idle");
        apply(mk(6'b101001, L1W, 4'd3), "rl_load");
        reset = 1'b0;
        apply(mk(6'b101001, IDL, 4'd0), "rl_async");
        reset = 1'b1;
        apply(mk(6'b111101, IDL, 4'd0), "rl_tie");
        for (int w = 0; w < BL; w++) begin
            apply(mk(6'b111101, L1W, 4'd0), $sformatf("rl_w%0d", w));
        end
        apply(mk(6'b000000, ZER, 4'd0), "rd_fin");
        apply(mk(6'b000000, DRN, 4'd4), "rd_drain");
        reset = 1'b0;
        apply(mk(6'b000000, IDL, 4'd0), "rd_async");
        reset = 1'b1;
        apply(mk(6'b000000, IDL, 4'd0), "rd_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
